rvx_irq_controller: RTL and testbench

Memory-mapped interrupt controller that sits directly downstream of the timer and other interrupt-producing peripherals. It collects up to NUM_SOURCES request lines, with source 0 wired to the timer's timer_irq by convention. Requests are masked with an enable register and resolved by fixed priority, lowest index wins. The block drives a single registered cpu_irq line to the core, with a claim/complete handshake on the same 5-bit IO interface used by the other rvx peripherals.

---
 rtl/rvx_irq_controller.sv | 164 ++++++++++++++++
 tb/tb_rvx_irq_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_irq_controller.sv
// Memory-mapped interrupt controller: sync, mask, fixed-priority claim/complete, registered cpu_irq.
// Latency: register reads/writes respond 1 cycle after request; level input to cpu_irq is 2 edges.
// Backpressure: none; every request is acknowledged next cycle. RVX_IRQC_EDGE_EN adds edge-mode TRIGGER.
module rvx_irq_controller #(
   parameter int NUM_SOURCES = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [4:0]             rw_address,
   output logic [31:0]            read_data,
   input  logic                   read_request,
   output logic                   read_response,
   input  logic [31:0]            write_data,
   input  logic [3:0]             write_strobe,
   input  logic                   write_request,
   output logic                   write_response,
   input  logic [NUM_SOURCES-1:0] irq_sources,
   output logic                   cpu_irq
);
   localparam int N = NUM_SOURCES;

   typedef enum logic {IDLE, IN_SERVICE} state_t;

   state_t         state_q, state_d;
   logic [4:0]     claimed_id_q, claimed_id_d;
   logic [N-1:0]   sync_q;
   logic [N-1:0]   enable_q, enable_d;
   logic [N-1:0]   pending, pend_en;
   logic [31:0]    read_data_q, read_data_d;
   logic           read_response_q, write_response_q, cpu_irq_q;
   logic [4:0]     cand_id;
   logic           claim_take;

   logic           wr_valid;
   logic [31:0]    wr_mask, wr_bits;
   logic           wr_enable, wr_complete, rd_claim;
   logic           unused_wr;

   // Only full-word, low-half and low-byte writes take effect; lanes select which bits change.
   assign wr_valid    = write_request && ((write_strobe == 4'b1111) ||
                                          (write_strobe == 4'b0011) ||
                                          (write_strobe == 4'b0001));
   assign wr_mask     = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                         {8{write_strobe[1]}}, {8{write_strobe[0]}}};
   assign wr_bits     = write_data & wr_mask;
   assign wr_enable   = wr_valid && (rw_address == 5'h04);
   assign wr_complete = wr_valid && (rw_address == 5'h0C);
   assign rd_claim    = read_request && (rw_address == 5'h08);
   assign unused_wr   = ^{wr_mask, wr_bits};

`ifdef RVX_IRQC_EDGE_EN
   logic [N-1:0] trigger_q, trigger_d;
   logic [N-1:0] sync_dly_q;
   logic [N-1:0] edge_pend_q, edge_pend_d;
   logic [N-1:0] cand_oh, rise, clr;
   logic         wr_pending, wr_trigger;

   assign wr_pending = wr_valid && (rw_address == 5'h00);
   assign wr_trigger = wr_valid && (rw_address == 5'h10);
   assign pending    = (edge_pend_q & trigger_q) | (sync_q & ~trigger_q);
   assign cand_oh    = pend_en & ~(pend_en - N'(1));

   // Edge pending: W1C and claim clear, a new rising edge overrides both.
   always_comb begin
      rise        = sync_q & ~sync_dly_q & trigger_q;
      clr         = (wr_pending ? wr_bits[N-1:0] : '0) | (claim_take ? cand_oh : '0);
      edge_pend_d = ((edge_pend_q & ~clr) | rise) & trigger_q;
      trigger_d   = wr_trigger ? ((trigger_q & ~wr_mask[N-1:0]) | wr_bits[N-1:0]) : trigger_q;
   end

   // Edge-mode state registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         trigger_q   <= '0;
         sync_dly_q  <= '0;
         edge_pend_q <= '0;
      end else begin
         trigger_q   <= trigger_d;
         sync_dly_q  <= sync_q;
         edge_pend_q <= edge_pend_d;
      end
   end
`else
   assign pending = sync_q;
`endif

   assign pend_en = pending & enable_q;

   // Fixed priority: lowest index wins, id is index+1, 0 means nothing to claim.
   always_comb begin
      cand_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_en[i]) cand_id = 5'(i + 1);
      end
   end

   // Claim/complete FSM next state.
   always_comb begin
      state_d      = state_q;
      claimed_id_d = claimed_id_q;
      claim_take   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_claim && (cand_id != 5'd0)) begin
               state_d      = IN_SERVICE;
               claimed_id_d = cand_id;
               claim_take   = 1'b1;
            end
         end
         IN_SERVICE: begin
            if (wr_complete && (wr_bits[4:0] == claimed_id_q)) begin
               state_d      = IDLE;
               claimed_id_d = '0;
            end
         end
      endcase
   end

   // Read mux and enable register update; read_data only changes on a read.
   always_comb begin
      read_data_d = read_data_q;
      enable_d    = wr_enable ? ((enable_q & ~wr_mask[N-1:0]) | wr_bits[N-1:0]) : enable_q;
      if (read_request) begin
         case (rw_address)
            5'h00:   read_data_d = 32'(pending);
            5'h04:   read_data_d = 32'(enable_q);
            5'h08:   read_data_d = (state_q == IDLE) ? 32'(cand_id) : 32'(claimed_id_q);
            5'h0C:   read_data_d = {state_q == IN_SERVICE, 26'b0, claimed_id_q};
`ifdef RVX_IRQC_EDGE_EN
            5'h10:   read_data_d = 32'(trigger_q);
`endif
            default: read_data_d = '0;
         endcase
      end
   end

   // Core state, synchronizers and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         claimed_id_q     <= '0;
         sync_q           <= '0;
         enable_q         <= '0;
         read_data_q      <= '0;
         read_response_q  <= 1'b0;
         write_response_q <= 1'b0;
         cpu_irq_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         claimed_id_q     <= claimed_id_d;
         sync_q           <= irq_sources;
         enable_q         <= enable_d;
         read_data_q      <= read_data_d;
         read_response_q  <= read_request;
         write_response_q <= write_request;
         cpu_irq_q        <= (state_q == IDLE) && (|pend_en);
      end
   end

   assign read_data      = read_data_q;
   assign read_response  = read_response_q;
   assign write_response = write_response_q;
   assign cpu_irq        = cpu_irq_q;
endmodule

// File: tb/tb_rvx_irq_controller.sv
// Bench for rvx_irq_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rvx_irq_controller;
   localparam int N = 8;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [4:0]    rw_address;
   logic [31:0]   read_data;
   logic          read_request;
   logic          read_response;
   logic [31:0]   write_data;
   logic [3:0]    write_strobe;
   logic          write_request;
   logic          write_response;
   logic [N-1:0]  irq_sources;
   logic          cpu_irq;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   rvx_irq_controller #(.NUM_SOURCES(N)) dut (
      .clock(clock), .reset_n(reset_n), .rw_address(rw_address),
      .read_data(read_data), .read_request(read_request), .read_response(read_response),
      .write_data(write_data), .write_strobe(write_strobe), .write_request(write_request),
      .write_response(write_response), .irq_sources(irq_sources), .cpu_irq(cpu_irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0] m_sync, m_sync_d, m_epend, m_en, m_trig;
   bit           m_busy, m_rresp, m_wresp, m_irq;
   int           m_cid;
   logic [31:0]  m_rdata;

   function automatic bit is_edge(input int i);
`ifdef RVX_IRQC_EDGE_EN
      return m_trig[i];
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit pend(input int i);
      return is_edge(i) ? m_epend[i] : m_sync[i];
   endfunction

   function automatic int best_id();
      for (int i = 0; i < N; i++) if (pend(i) && m_en[i]) return i + 1;
      return 0;
   endfunction

   always @(posedge clock) begin : model
      logic [31:0]  pw, bm, wd;
      logic [N-1:0] ep_next;
      int           cand;
      bit           vw, claim, any;
      if (!reset_n) begin
         m_sync = '0; m_sync_d = '0; m_epend = '0; m_en = '0; m_trig = '0;
         m_busy = 0; m_cid = 0; m_rdata = '0; m_rresp = 0; m_wresp = 0; m_irq = 0;
      end else begin
         pw = '0;
         any = 0;
         for (int i = 0; i < N; i++) begin
            pw[i] = pend(i);
            if (pend(i) && m_en[i]) any = 1;
         end
         cand = best_id();
         vw = write_request && (write_strobe inside {4'b1111, 4'b0011, 4'b0001});
         bm = '0;
         for (int b = 0; b < 4; b++) if (write_strobe[b]) bm[8*b +: 8] = 8'hFF;
         wd = write_data & bm;
         m_rresp = read_request;
         m_wresp = write_request;
         m_irq   = !m_busy && any;
         claim   = read_request && rw_address == 5'h08 && !m_busy && cand != 0;
         if (read_request) begin
            case (rw_address)
               5'h00:   m_rdata = pw;
               5'h04:   m_rdata = 32'(m_en);
               5'h08:   m_rdata = m_busy ? 32'(m_cid) : 32'(cand);
               5'h0C:   m_rdata = (m_busy ? 32'h8000_0000 : 32'h0) + 32'(m_cid);
`ifdef RVX_IRQC_EDGE_EN
               5'h10:   m_rdata = 32'(m_trig);
`endif
               default: m_rdata = '0;
            endcase
         end
         for (int i = 0; i < N; i++) begin
            if (!is_edge(i)) ep_next[i] = 1'b0;
            else ep_next[i] = (m_sync[i] && !m_sync_d[i]) ||
                              (m_epend[i] && !(vw && rw_address == 5'h00 && wd[i])
                                          && !(claim && cand == i + 1));
         end
         if (claim) begin
            m_busy = 1; m_cid = cand;
         end else if (m_busy && vw && rw_address == 5'h0C && int'(wd[4:0]) == m_cid) begin
            m_busy = 0; m_cid = 0;
         end
         if (vw && rw_address == 5'h04) m_en = (m_en & ~bm[N-1:0]) | wd[N-1:0];
`ifdef RVX_IRQC_EDGE_EN
         if (vw && rw_address == 5'h10) m_trig = (m_trig & ~bm[N-1:0]) | wd[N-1:0];
`endif
         m_epend  = ep_next;
         m_sync_d = m_sync;
         m_sync   = irq_sources;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_on) begin
         check("read_response", 32'(read_response), 32'(m_rresp));
         check("write_response", 32'(write_response), 32'(m_wresp));
         check("read_data", read_data, m_rdata);
         check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
      end
   end

   // ---------------- driver helpers (called at negedge) ----------------
   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      read_request = 1; rw_address = a;
      @(negedge clock);
      read_request = 0;
      check("rd_response", 32'(read_response), 32'd1);
      d = read_data;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
      write_request = 1; rw_address = a; write_data = v; write_strobe = s;
      @(negedge clock);
      write_request = 0;
      check("wr_response", 32'(write_response), 32'd1);
   endtask

   task automatic pulse0();
      irq_sources[0] = 1'b1;
      @(negedge clock);
      irq_sources[0] = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int op;
      logic [4:0] a;
      reset_n = 0; rw_address = 0; read_request = 0; write_request = 0;
      write_data = 0; write_strobe = 0; irq_sources = 0;
      repeat (3) @(negedge clock);
      reset_n = 1; chk_on = 1;

      // Reset state
      check("rst_cpu_irq", 32'(cpu_irq), 0);
      check("rst_read_response", 32'(read_response), 0);
      check("rst_read_data", read_data, 0);
      rd(5'h00, d); check("rst_pending", d, 0);
      rd(5'h04, d); check("rst_enable", d, 0);
      rd(5'h0C, d); check("rst_status", d, 0);

      // Single level source, claim and complete
      wr(5'h04, 32'h1, 4'hF);
      irq_sources = 8'h01;
      @(negedge clock); check("lvl_cpu_edge1", 32'(cpu_irq), 0);
      @(negedge clock); check("lvl_cpu_edge2", 32'(cpu_irq), 1);
      rd(5'h08, d); check("claim_src0", d, 1);
      @(negedge clock); check("cpu_drop_after_claim", 32'(cpu_irq), 0);
      rd(5'h0C, d); check("status_busy1", d, 32'h8000_0001);
      wr(5'h0C, 32'h1, 4'hF);
      @(negedge clock); check("cpu_reassert", 32'(cpu_irq), 1);
      irq_sources = 0;
      repeat (3) @(negedge clock);

      // Priority and mismatched completion
      wr(5'h04, 32'h6, 4'hF);
      irq_sources = 8'h06;
      repeat (2) @(negedge clock);
      rd(5'h08, d); check("claim_prio", d, 2);
      wr(5'h0C, 32'h3, 4'hF);
      rd(5'h0C, d); check("status_after_bad_complete", d, 32'h8000_0002);
      rd(5'h08, d); check("claim_in_service", d, 2);
      wr(5'h0C, 32'h2, 4'hF);
      @(negedge clock); check("cpu_after_complete", 32'(cpu_irq), 1);
      irq_sources = 8'h04;
      repeat (2) @(negedge clock);
      rd(5'h08, d); check("claim_next", d, 3);
      wr(5'h0C, 32'h3, 4'hF);
      irq_sources = 0;
      repeat (2) @(negedge clock);

      // Masked source
      wr(5'h04, 32'h0, 4'hF);
      irq_sources = 8'h01;
      repeat (3) @(negedge clock);
      check("masked_cpu", 32'(cpu_irq), 0);
      rd(5'h00, d); check("masked_pending", d, 1);
      rd(5'h08, d); check("masked_claim", d, 0);
      rd(5'h0C, d); check("masked_status", d, 0);
      irq_sources = 0;

      // Strobe handling
      wr(5'h04, 32'hFF, 4'b0100);
      rd(5'h04, d); check("bad_strobe_enable", d, 0);
      wr(5'h04, 32'hFFFF_FF5A, 4'b0001);
      rd(5'h04, d); check("byte_strobe_enable", d, 32'h5A);
      wr(5'h04, 32'h0, 4'hF);
      repeat (2) @(negedge clock);

`ifdef RVX_IRQC_EDGE_EN
      wr(5'h10, 32'h1, 4'hF);
      wr(5'h04, 32'h1, 4'hF);
      rd(5'h10, d); check("trigger_rw", d, 1);
      pulse0();
      repeat (3) @(negedge clock);
      rd(5'h00, d); check("edge_pending", d, 1);
      repeat (5) @(negedge clock);
      rd(5'h00, d); check("edge_persist", d, 1);
      rd(5'h08, d); check("edge_claim", d, 1);
      rd(5'h00, d); check("edge_claim_clears", d, 0);
      wr(5'h0C, 32'h1, 4'hF);
      pulse0();
      repeat (3) @(negedge clock);
      rd(5'h00, d); check("edge_pending2", d, 1);
      irq_sources[0] = 1'b1;
      @(negedge clock);
      irq_sources[0] = 1'b0;
      wr(5'h00, 32'h1, 4'hF);
      rd(5'h00, d); check("set_beats_w1c", d, 1);
      wr(5'h00, 32'h1, 4'hF);
      rd(5'h00, d); check("w1c_clears", d, 0);
      wr(5'h04, 32'h0, 4'hF);
      wr(5'h10, 32'h0, 4'hF);
`else
      wr(5'h10, 32'h1, 4'hF);
      rd(5'h10, d); check("trigger_absent", d, 0);
`endif

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) irq_sources[i] = ~irq_sources[i];
         reset_n = ($urandom_range(0, 599) != 0);
         read_request = 0; write_request = 0;
         op = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(4 * $urandom_range(0, 4));
         rw_address = a;
         if (op < 3) begin
            read_request = 1;
         end else if (op < 6) begin
            write_request = 1;
            write_strobe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            write_data = $urandom;
            if (a == 5'h0C && $urandom_range(0, 1) == 1) write_data = 32'(m_cid);
            if (a == 5'h00) write_data = 32'($urandom_range(0, 255));
         end
         @(negedge clock);
      end
      reset_n = 1; read_request = 0; write_request = 0;
      repeat (4) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
